// File: rtl/coherence_bus_ctrl_pkg.sv
// cpu_types_pkg / caches_types_pkg: RAM handshake states and shared-bus controller types.
package cpu_types_pkg;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

package caches_types_pkg;
    localparam int CPUS     = 2;
    localparam int BLKWORDS = 2;
    typedef enum logic [2:0] {IDLE, SNOOP, C2C0, C2C1, LD0, LD1, WB, IF} bus_state_t;
endpackage

// File: rtl/coherence_bus_ctrl_arb.sv
// rr_arb2: two-way round-robin arbiter; pointer moves past the winner when a grant is taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic       gnt,
    output logic       vld
);
    logic ptr_q, ptr_d;

    always_comb begin
        gnt   = req[ptr_q] ? ptr_q : ~ptr_q;
        vld   = |req;
        ptr_d = (en && vld) ? ~gnt : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
endmodule

// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: two-core MSI snooping bus controller in front of a single-port RAM.
module coherence_bus_ctrl
    import cpu_types_pkg::*;
    import caches_types_pkg::*;
(
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [CPUS-1:0]       iREN,
    input  logic [CPUS-1:0][31:0] iaddr,
    output logic [CPUS-1:0]       iwait,
    output logic [CPUS-1:0][31:0] iload,
    input  logic [CPUS-1:0]       dREN,
    input  logic [CPUS-1:0]       dWEN,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    output logic [CPUS-1:0]       dwait,
    output logic [CPUS-1:0][31:0] dload,
    input  logic [CPUS-1:0]       cctrans,
    input  logic [CPUS-1:0]       ccwrite,
    output logic [CPUS-1:0]       ccwait,
    output logic [CPUS-1:0]       ccinv,
    output logic [CPUS-1:0][31:0] ccsnoopaddr,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic [31:0]           ramload,
    input  ramstate_t             ramstate
);
    bus_state_t  state_q, state_d;
    logic        r_q, r_d, inv_q, inv_d;
    logic [31:0] addr_q, addr_d;
    logic        s, acc, dgnt, dvld, ignt, ivld;

    assign s   = ~r_q;
    assign acc = (ramstate == ACCESS);

    // Coherence requests shadow writebacks inside the shared data-class arbiter.
    rr_arb2 u_darb (
        .clk(CLK), .rst_n(nRST), .req(|cctrans ? cctrans : dWEN),
        .en(state_q == IDLE), .gnt(dgnt), .vld(dvld)
    );

    rr_arb2 u_iarb (
        .clk(CLK), .rst_n(nRST), .req(iREN),
        .en(state_q == IDLE && !dvld), .gnt(ignt), .vld(ivld)
    );

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        addr_d      = addr_q;
        inv_d       = inv_q;
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        if (state_q inside {SNOOP, C2C0, C2C1, LD0, LD1}) begin
            ccwait[s]      = 1'b1;
            ccsnoopaddr[s] = addr_q;
            ccinv[s]       = inv_q;
        end
        case (state_q)
            IDLE: begin
                if (dvld) begin
                    r_d     = dgnt;
                    addr_d  = |cctrans ? daddr[dgnt] : addr_q;
                    inv_d   = |cctrans ? ccwrite[dgnt] : inv_q;
                    state_d = |cctrans ? SNOOP : WB;
                end else if (ivld) begin
                    r_d     = ignt;
                    state_d = IF;
                end
            end
            SNOOP: state_d = ccwrite[s] ? C2C0 : (!dREN[r_q] ? IDLE : LD0);
            C2C0, C2C1: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[s];
                ramstore = dstore[s];
                if (acc) begin
                    dwait[s]   = 1'b0;
                    dwait[r_q] = 1'b0;
                    dload[r_q] = dstore[s];
                    state_d    = (state_q == C2C0) ? C2C1 : IDLE;
                end
            end
            LD0, LD1: begin
                ramREN  = 1'b1;
                ramaddr = daddr[r_q];
                if (acc) begin
                    dwait[r_q] = 1'b0;
                    dload[r_q] = ramload;
                    state_d    = (state_q == LD0) ? LD1 : IDLE;
                end
            end
            WB: begin
                // Strobe follows dWEN so the cycle that ends a burst issues no stray write.
                ramWEN     = dWEN[r_q];
                ramaddr    = daddr[r_q];
                ramstore   = dstore[r_q];
                dwait[r_q] = ~(acc && dWEN[r_q]);
                state_d    = dWEN[r_q] ? WB : IDLE;
            end
            IF: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[r_q];
                if (acc) begin
                    iwait[r_q] = 1'b0;
                    iload[r_q] = ramload;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            state_q <= IDLE;
            r_q     <= 1'b0;
            inv_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            inv_q   <= inv_d;
            addr_q  <= addr_d;
        end
endmodule
